// File: rtl/vga_pkg.sv
// Shared timing defaults and counter width for the VGA raster sequencer.
// The defaults describe 800x600@60 Hz on a 40 MHz pixel clock.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  localparam int DEF_HS_POL = 1;
  localparam int DEF_VS_POL = 1;

  // Total length of one axis (active + porches + sync).
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/itf_vga_no_rgb.sv
// VGA timing bundle without colour: counters, syncs and blanking for both axes.
interface itf_vga_no_rgb;
  logic [vga_pkg::CNT_W-1:0] vcount;
  logic                      vsync;
  logic                      vblnk;
  logic [vga_pkg::CNT_W-1:0] hcount;
  logic                      hsync;
  logic                      hblnk;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: a wrapping position counter with registered blank/sync decodes.
// Decodes are computed from the next count so they always describe the pixel the
// counter is presenting. wrap is combinational: high when this edge will wrap.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter int POL    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACTIVE_C     = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START_C = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END_C   = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic             POL_L        = (POL != 0);

  // The counter cannot represent an axis longer than its width allows.
  if (TOTAL > (1 << CNT_W)) begin : g_total_check
    $error("vga_axis_cnt: axis total %0d exceeds %0d-bit counter range", TOTAL, CNT_W);
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;
  logic             at_last;

  assign at_last = (count_q == LAST_C);

  // Next count and the decodes of that next count.
  always_comb begin
    count_d = count_q;
    if (advance) begin
      count_d = at_last ? '0 : count_q + CNT_W'(1);
    end
    blnk_d = (count_d >= ACTIVE_C);
    sync_d = ((count_d >= SYNC_START_C) && (count_d < SYNC_END_C)) ? POL_L : ~POL_L;
  end

  // State register; reset parks at position 0 with sync idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL_L;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;
  assign wrap  = advance && at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster sequencer with clock-enable and line/frame start strobes.
// The vertical axis advances only on the edge where the horizontal axis wraps.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = DEF_HS_POL,
  parameter int VS_POL   = DEF_VS_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  itf_vga_no_rgb.out       vga_out,
  output logic             line_start,
  output logic             frame_start
);

  logic [CNT_W-1:0] h_count, v_count;
  logic             h_blnk, h_sync, h_wrap;
  logic             v_blnk, v_sync, v_wrap;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (en),
    .count   (h_count),
    .blnk    (h_blnk),
    .sync    (h_sync),
    .wrap    (h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (h_wrap),
    .count   (v_count),
    .blnk    (v_blnk),
    .sync    (v_sync),
    .wrap    (v_wrap)
  );

  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Strobes fire after an enabled wrap; with en low h_wrap is low, so they drop to 0.
  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  // Strobe registers; reset never produces a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  assign vga_out.hcount = h_count;
  assign vga_out.hblnk  = h_blnk;
  assign vga_out.hsync  = h_sync;
  assign vga_out.vcount = v_count;
  assign vga_out.vblnk  = v_blnk;
  assign vga_out.vsync  = v_sync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two builds (small raster with active-high syncs, default 800x600
// with active-low hsync) share en/rst; a frame-position model predicts every cycle.
module tb_vga_timing_gen;

  // Small raster so whole frames fit in the run.
  localparam int AHA = 16, AHF = 2, AHS = 4, AHB = 3;
  localparam int AVA = 10, AVF = 1, AVS = 2, AVB = 3;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  // Default raster, active-low hsync.
  localparam int BHA = 800, BHF = 40, BHS = 128, BHB = 88;
  localparam int BVA = 600, BVF = 1, BVS = 4, BVB = 23;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic ls_a, fs_a, ls_b, fs_b;

  itf_vga_no_rgb vga_a ();
  itf_vga_no_rgb vga_b ();

  vga_timing_gen #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HS_POL(1), .VS_POL(1)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .vga_out(vga_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .HS_POL(0), .VS_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .vga_out(vga_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  obs_t qa[$];
  obs_t qb[$];

  // Model: position inside the frame as one linear pixel index.
  int pa = 0, pb = 0;
  bit lsa = 0, fsa = 0, lsb = 0, fsb = 0;

  function automatic obs_t predict(input int p, input int ha, input int hf, input int hsw,
                                   input int hbp, input int va, input int vf, input int vsw,
                                   input int vbp, input bit hpol, input bit vpol,
                                   input bit ls, input bit fs);
    obs_t o;
    int ht, h, v;
    ht = ha + hf + hsw + hbp;
    h  = p % ht;
    v  = p / ht;
    o.hc = 11'(h);
    o.vc = 11'(v);
    o.hb = (h >= ha);
    o.vb = (v >= va);
    o.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? hpol : !hpol;
    o.vs = ((v >= va + vf) && (v < va + vf + vsw)) ? vpol : !vpol;
    o.ls = ls;
    o.fs = fs;
    return o;
  endfunction

  task automatic model_reset();
    pa = 0; pb = 0;
    lsa = 0; fsa = 0; lsb = 0; fsb = 0;
  endtask

  task automatic model_step(input bit e);
    if (e) begin
      pa  = (pa + 1) % (AHT * AVT);
      pb  = (pb + 1) % (BHT * BVT);
      lsa = (pa % AHT == 0); fsa = (pa == 0);
      lsb = (pb % BHT == 0); fsb = (pb == 0);
    end else begin
      lsa = 0; fsa = 0; lsb = 0; fsb = 0;
    end
  endtask

  task automatic push_expected();
    qa.push_back(predict(pa, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b1, 1'b1, lsa, fsa));
    qb.push_back(predict(pb, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b0, 1'b1, lsb, fsb));
  endtask

  // One cycle of stimulus, applied between edges. mode 0: normal, 1: reset held
  // through the edge, 2: reset pulsed asynchronously and released before the edge.
  task automatic drive_cycle(input int mode, input bit e);
    @(negedge clk);
    #2;
    en = e;
    if (mode == 1) begin
      rst = 1'b1;
      model_reset();
    end else if (mode == 2) begin
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
      model_step(e);
    end else begin
      rst = 1'b0;
      model_step(e);
    end
    push_expected();
  endtask

  function automatic obs_t sample_a();
    obs_t o;
    o = {vga_a.hcount, vga_a.vcount, vga_a.hsync, vga_a.vsync, vga_a.hblnk, vga_a.vblnk, ls_a, fs_a};
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o = {vga_b.hcount, vga_b.vcount, vga_b.hsync, vga_b.vsync, vga_b.hblnk, vga_b.vblnk, ls_b, fs_b};
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t exp_o);
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL %s cyc=%0d got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b want hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b",
               name, cyc, got.hc, got.vc, got.hs, got.vs, got.hb, got.vb, got.ls, got.fs,
               exp_o.hc, exp_o.vc, exp_o.hs, exp_o.vs, exp_o.hb, exp_o.vb, exp_o.ls, exp_o.fs);
    end
  endtask

  // Monitor: every cycle the DUT presents a new raster position; compare on the falling edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare("small_raster", sample_a(), e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare("default_raster", sample_b(), e);
      end
    end
  end

  // Stimulus.
  initial begin
    int  guard;
    int  r;
    model_reset();
    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) drive_cycle(1, 1'b1);
    // Free run: covers hblnk at 800, hsync 840..967 and two line wraps on the default raster.
    for (int i = 0; i < 2200; i++) drive_cycle(0, 1'b1);
    // Park the small raster on its last pixel, then toggle en 1-0-0-1 across the frame wrap.
    guard = 0;
    while (pa != AHT * AVT - 1 && guard < AHT * AVT + 4) begin
      drive_cycle(0, 1'b1);
      guard++;
    end
    checks++;
    if (pa != AHT * AVT - 1) begin
      errors++;
      $display("FAIL park_last_pixel got position %0d want %0d", pa, AHT * AVT - 1);
    end
    drive_cycle(0, 1'b0);
    drive_cycle(0, 1'b0);
    drive_cycle(0, 1'b1);
    drive_cycle(0, 1'b1);
    drive_cycle(0, 1'b0);
    drive_cycle(0, 1'b1);
    // Mid-frame asynchronous reset pulse between edges.
    for (int i = 0; i < AHT * 5 + 7; i++) drive_cycle(0, 1'b1);
    drive_cycle(2, 1'b1);
    for (int i = 0; i < 40; i++) drive_cycle(0, 1'b1);
    // Randomised enable with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        drive_cycle(2, ($urandom_range(0, 1) == 1));
      end else if (r < 3) begin
        for (int k = 0; k < 3; k++) drive_cycle(1, 1'b1);
      end else begin
        drive_cycle(0, ($urandom_range(0, 9) != 0));
      end
    end
    // Let the monitor drain the queues.
    guard = 0;
    while ((qa.size() > 0 || qb.size() > 0) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
